// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer block:
// register offsets, CTRL field positions and reset defaults.
package mtimer_pkg;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_DIV_LSB    = 8;

    localparam logic [63:0] RST_CMP_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_e;

    // Map a word index (byte offset bits [4:2]) to a register.
    function automatic reg_sel_e decode_word(input logic [2:0] word);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == OFF_MTIME_LO[4:2])    sel = SEL_MTIME_LO;
        if (word == OFF_MTIME_HI[4:2])    sel = SEL_MTIME_HI;
        if (word == OFF_MTIMECMP_LO[4:2]) sel = SEL_CMP_LO;
        if (word == OFF_MTIMECMP_HI[4:2]) sel = SEL_CMP_HI;
        if (word == OFF_CTRL[4:2])        sel = SEL_CTRL;
        return sel;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divide-by-(div+1) tick generator for mtime.
// Count runs 0..div and wraps; held at 0 when disabled.
module mtimer_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Tick on the terminal count, restart from 0 on tick/clear/disable.
    always_comb begin
        tick    = enable && (count_q == div);
        count_d = count_q + DIV_W'(1);
        if (clear || !enable || tick) begin
            count_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Machine timer: free-running mcycle, prescaled mtime,
// mtimecmp compare interrupt and a one-cycle-ack register bus.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter logic [63:0] RST_CMP = RST_CMP_DEFAULT
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_CS,
    input  logic        i_WE,
    input  logic [4:0]  i_ADDR,
    input  logic [31:0] i_WDATA,
    output logic [31:0] o_RDATA,
    output logic        o_ACK,
    output logic [63:0] o_MCYCLE,
    output logic        o_TIMER_IRQ
);

    logic [63:0]      mcycle_q,   mcycle_d;
    logic [63:0]      mtime_q,    mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [31:0]      shadow_q,   shadow_d;
    logic             en_q,       en_d;
    logic             irq_en_q,   irq_en_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             ack_q,      ack_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic             irq_q,      irq_d;

    reg_sel_e    sel;
    logic        wr;
    logic        rd;
    logic        tick;
    logic        ctrl_wr;
    logic [31:0] ctrl_rd;
    logic        addr_unused;

    // Byte lane bits carry no meaning on this word-only bus.
    assign addr_unused = ^i_ADDR[1:0];

    assign sel     = decode_word(i_ADDR[4:2]);
    assign wr      = i_CS && i_WE;
    assign rd      = i_CS && !i_WE;
    assign ctrl_wr = wr && (sel == SEL_CTRL);

    mtimer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .i_CLK  (i_CLK),
        .i_RSTn (i_RSTn),
        .enable (en_q),
        .div    (div_q),
        .clear  (ctrl_wr),
        .tick   (tick)
    );

    // Assemble the CTRL readback word; unused bits read 0.
    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CTRL_EN_BIT]                 = en_q;
        ctrl_rd[CTRL_IRQ_EN_BIT]             = irq_en_q;
        ctrl_rd[CTRL_DIV_LSB +: DIV_W]       = div_q;
    end

    // Next state of the timer registers; bus writes beat ticks.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        div_d      = div_q;
        if (wr && (sel == SEL_MTIME_LO)) begin
            mtime_d[31:0] = i_WDATA;
        end else if (wr && (sel == SEL_MTIME_HI)) begin
            mtime_d[63:32] = i_WDATA;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr && (sel == SEL_CMP_LO)) begin
            mtimecmp_d[31:0] = i_WDATA;
        end
        if (wr && (sel == SEL_CMP_HI)) begin
            mtimecmp_d[63:32] = i_WDATA;
        end
        if (ctrl_wr) begin
            en_d     = i_WDATA[CTRL_EN_BIT];
            irq_en_d = i_WDATA[CTRL_IRQ_EN_BIT];
            div_d    = i_WDATA[CTRL_DIV_LSB +: DIV_W];
        end
    end

    // Read mux, shadow capture for atomic 64-bit reads, ack and irq.
    always_comb begin
        ack_d    = i_CS;
        rdata_d  = '0;
        shadow_d = shadow_q;
        irq_d    = irq_en_q && (mtime_q >= mtimecmp_q);
        if (rd) begin
            unique case (sel)
                SEL_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                SEL_MTIME_HI: rdata_d = shadow_q;
                SEL_CMP_LO:   rdata_d = mtimecmp_q[31:0];
                SEL_CMP_HI:   rdata_d = mtimecmp_q[63:32];
                SEL_CTRL:     rdata_d = ctrl_rd;
                default:      rdata_d = '0;
            endcase
        end
    end

    // State registers with asynchronous reset to documented defaults.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            mcycle_q   <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= RST_CMP;
            shadow_q   <= '0;
            en_q       <= 1'b1;
            irq_en_q   <= 1'b0;
            div_q      <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            shadow_q   <= shadow_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            div_q      <= div_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign o_MCYCLE    = mcycle_q;
    assign o_ACK       = ack_q;
    assign o_RDATA     = rdata_q;
    assign o_TIMER_IRQ = irq_q;

endmodule

// File: doc/mtimer.md
MTIMER -- requirements
Module: mtimer

Interface
REQ-001 Parameter: DIV_W, default 8, width of the prescaler divide field and counter.
REQ-002 Parameter: RST_CMP, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: i_CLK  input  1  clock, all state on rising edge.
REQ-005 Port: i_RSTn  input  1  asynchronous active-low reset.
REQ-006 Port: i_CS  input  1  bus select, one-cycle request strobe.
REQ-007 Port: i_WE  input  1  1 = write, 0 = read; valid with i_CS.
REQ-008 Port: i_ADDR  input  5  byte offset; bits [1:0] ignored.
REQ-009 Port: i_WDATA  input  32  write data.
REQ-010 Port: o_RDATA  output  32  registered read data, valid with o_ACK.
REQ-011 Port: o_ACK  output  1  one-cycle acknowledge.
REQ-012 Port: o_MCYCLE  output  64  free-running cycle count; feeds the CSR cycle input.
REQ-013 Port: o_TIMER_IRQ  output  1  registered level timer interrupt; feeds one machine external interrupt line.

Function
REQ-014 o_MCYCLE SHALL increment by 1 on every clock after reset release and wrap from 2^64-1 to 0; it is not writable.
REQ-015 Register map SHALL be: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL.
REQ-016 CTRL SHALL contain: [0] EN (timer count enable), [1] IRQ_EN, [DIV_W+7:8] DIV; other bits read 0.
REQ-017 Prescaler SHALL count 0..DIV while EN=1; the tick fires on the cycle the count equals DIV, and the count returns to 0. mtime therefore advances once every DIV+1 cycles; DIV=0 advances every cycle.
REQ-018 When EN=0, the prescaler count SHALL hold at 0 and mtime SHALL hold its value.
REQ-019 On a tick, mtime SHALL increment by 1 as a full 64-bit add with wrap to 0.
REQ-020 A bus write to MTIME_LO or MTIME_HI SHALL replace that half. It takes priority over a same-cycle tick, and that tick is dropped.
REQ-021 A bus write to CTRL SHALL reset the prescaler count to 0.
REQ-022 o_TIMER_IRQ SHALL equal IRQ_EN AND (mtime >= mtimecmp), unsigned 64-bit, registered with one cycle of latency from the register state.
REQ-023 The IRQ is a level. It deasserts only when mtimecmp is raised above mtime, mtime is rewritten below mtimecmp, or IRQ_EN is cleared.
REQ-024 Every i_CS cycle SHALL produce o_ACK=1 exactly on the next cycle. Back-to-back requests are accepted every cycle with no stall.
REQ-025 Reads SHALL return data sampled in the request cycle. A read of MTIME_LO SHALL also latch mtime[63:32] into a shadow register, and MTIME_HI reads SHALL return that shadow value (atomic 64-bit read).
REQ-026 Unmapped offsets SHALL be acknowledged. Reads return 0 and writes are ignored.
REQ-027 o_RDATA SHALL be 0 whenever o_ACK=0.

Reset
REQ-028 While i_RSTn=0, the block SHALL hold the following values asynchronously: o_MCYCLE=0, mtime=0, shadow=0, mtimecmp=RST_CMP, CTRL.EN=1, CTRL.IRQ_EN=0, DIV=0, prescaler=0, o_ACK=0, o_RDATA=0, o_TIMER_IRQ=0.
REQ-029 A bus request in flight at reset assertion SHALL be discarded, with no o_ACK after release.

Structure
REQ-030 A shared package SHALL hold the register offsets, the CTRL bit positions and the RST_CMP default.
REQ-031 The prescaler SHALL be a sub-module, mtimer_prescaler (inputs enable, div, clear; output tick).

Verification
REQ-032 DIV=3, EN=1, mtime=0: after 12 cycles, mtime=3 and ticks occur every 4th cycle.
REQ-033 mtimecmp=10, IRQ_EN=1, DIV=0, mtime=0: o_TIMER_IRQ rises 1 cycle after mtime reaches 10. Then writing MTIMECMP_LO=100 drops the IRQ within 2 cycles.
REQ-034 mtime=0x0000_0000_FFFF_FFFF with a tick: the next read gives LO=0, HI=1. Also, reading LO when the value is 0x1_FFFF_FFFF and reading HI after a carry returns the pre-carry HI shadow value (1).
REQ-035 Write MTIME_LO=5 in the same cycle as a tick: mtime LO=5, not 6.
REQ-036 Read offset 0x14: o_ACK next cycle with o_RDATA=0. Two back-to-back reads return 2 consecutive ACKs.
REQ-037 Assert i_RSTn=0 mid-count with a pending request: all outputs reach their reset values immediately, o_TIMER_IRQ=0, and there is no ACK after release.
